stepdir_channel: RTL and testbench



---
 rtl/stepdir_channel_if.sv | 47 ++++
 rtl/stepdir_channel.sv | 180 ++++++++++++++++++
 tb/tb_stepdir_channel.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stepdir_channel_if.sv
// ----------------------------------------------------------------------------
// stepdir_channel_if: move queue, time base and step/dir outputs of one axis.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface stepdir_channel_if #(
  parameter int unsigned MOVE_TYPE_BITS     = 3,
  parameter int unsigned STEP_INTERVAL_BITS = 32,
  parameter int unsigned STEP_COUNT_BITS    = 32,
  parameter int unsigned STEP_ADD_BITS      = 32,
  parameter int unsigned MOVE_COUNT         = 16
);
  localparam int unsigned ENTRY_BITS = 1 + STEP_INTERVAL_BITS + STEP_COUNT_BITS
                                       + STEP_ADD_BITS + MOVE_TYPE_BITS;
  localparam int unsigned CNT_BITS   = $clog2(MOVE_COUNT);

  logic [ENTRY_BITS-1:0] queue_wr_data;
  logic                  queue_wr_en;
  logic                  queue_empty;
  logic                  queue_full;
  logic [CNT_BITS-1:0]   elemcnt;
  logic                  dedge;
  logic                  do_reset_clock;
  logic [31:0]           reset_clock;
  logic [31:0]           clock;
  logic                  step;
  logic                  dir;
  logic [31:0]           position;
  logic [31:0]           next_step_time;
  logic                  missed_clock;
  logic [15:0]           debug;

  modport master (
    output queue_wr_data, queue_wr_en, dedge, do_reset_clock, reset_clock, clock,
    input  queue_empty, queue_full, elemcnt, step, dir, position,
           next_step_time, missed_clock, debug
  );

  modport slave (
    input  queue_wr_data, queue_wr_en, dedge, do_reset_clock, reset_clock, clock,
    output queue_empty, queue_full, elemcnt, step, dir, position,
           next_step_time, missed_clock, debug
  );
endinterface

`default_nettype wire

// File: rtl/stepdir_channel.sv
// ----------------------------------------------------------------------------
// stepdir_channel: queued Klipper-style step/dir generator for one axis.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stepdir_channel #(
  parameter int unsigned                 MOVE_TYPE_BITS     = 3,
  parameter logic [MOVE_TYPE_BITS-1:0]   MOVE_TYPE_KLIPPER  = '0,
  parameter int unsigned                 STEP_INTERVAL_BITS = 32,
  parameter int unsigned                 STEP_COUNT_BITS    = 32,
  parameter int unsigned                 STEP_ADD_BITS      = 32,
  parameter int unsigned                 MOVE_COUNT         = 16,
  parameter int unsigned                 PULSE_WIDTH        = 20
) (
  input  logic             clk,
  input  logic             reset,
  stepdir_channel_if.slave bus
);
  localparam int unsigned EW = 1 + STEP_INTERVAL_BITS + STEP_COUNT_BITS
                               + STEP_ADD_BITS + MOVE_TYPE_BITS;
  localparam int unsigned CW = $clog2(MOVE_COUNT);
  localparam int unsigned PW = $clog2(PULSE_WIDTH + 1);
  localparam logic [31:0] LATE_THRESH = 32'hC000_0000;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [EW-1:0]                 mem_q [MOVE_COUNT];
  logic [CW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic                          missed_q, missed_d, pulse_q, pulse_d;
  logic [PW-1:0]                 pcnt_q, pcnt_d;
  logic [STEP_INTERVAL_BITS-1:0] interval_q, interval_d;
  logic [STEP_COUNT_BITS-1:0]    count_q, count_d;
  logic [STEP_ADD_BITS-1:0]      add_q, add_d;
  logic [31:0]                   nst_q, nst_d, last_q, last_d, pos_q, pos_d;
  logic                          dir_q, dir_d, tog_q, tog_d;

  logic [EW-1:0]                 head;
  logic                          h_dir;
  logic [STEP_INTERVAL_BITS-1:0] h_interval;
  logic [STEP_COUNT_BITS-1:0]    h_count;
  logic [STEP_ADD_BITS-1:0]      h_add;
  logic [MOVE_TYPE_BITS-1:0]     h_type;
  logic                          fifo_empty, fifo_full, push, pop, step_evt, due;
  logic [STEP_INTERVAL_BITS-1:0] interval_nx;
  logic [31:0]                   nst_load, nst_step;

  assign head       = mem_q[rd_ptr_q];
  assign h_type     = head[MOVE_TYPE_BITS-1:0];
  assign h_add      = head[MOVE_TYPE_BITS +: STEP_ADD_BITS];
  assign h_count    = head[MOVE_TYPE_BITS+STEP_ADD_BITS +: STEP_COUNT_BITS];
  assign h_interval = head[MOVE_TYPE_BITS+STEP_ADD_BITS+STEP_COUNT_BITS +: STEP_INTERVAL_BITS];
  assign h_dir      = head[EW-1];

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(MOVE_COUNT - 1));
  assign push       = bus.queue_wr_en & ~fifo_full;

  assign interval_nx = interval_q + STEP_INTERVAL_BITS'($signed(add_q));
  assign nst_load    = last_q + 32'(h_interval);
  assign nst_step    = nst_q + 32'(interval_nx);
  // A target at or behind the current time fires at once; far-past is wrap-safe.
  assign due         = (nst_q == bus.clock) || ((nst_q - bus.clock) >= LATE_THRESH);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    missed_d   = missed_q;
    pulse_d    = pulse_q;
    pcnt_d     = pcnt_q;
    interval_d = interval_q;
    count_d    = count_q;
    add_d      = add_q;
    nst_d      = nst_q;
    last_d     = last_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    tog_d      = tog_q;
    pop        = 1'b0;
    step_evt   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (h_type == MOVE_TYPE_KLIPPER && h_count != '0) begin
            state_d    = S_RUN;
            interval_d = h_interval;
            count_d    = h_count;
            add_d      = h_add;
            nst_d      = nst_load;
            dir_d      = h_dir;
            if ((nst_load - bus.clock) >= LATE_THRESH) missed_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (due) begin
          step_evt   = 1'b1;
          pos_d      = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
          last_d     = nst_q;
          interval_d = interval_nx;
          nst_d      = nst_step;
          count_d    = count_q - STEP_COUNT_BITS'(1);
          if (count_q == STEP_COUNT_BITS'(1)) begin
            state_d = S_IDLE;
          end else if ((nst_step - bus.clock) >= LATE_THRESH) begin
            missed_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.do_reset_clock) last_d = bus.reset_clock;

    if (step_evt && !bus.dedge) begin
      pulse_d = 1'b1;
      pcnt_d  = PW'(PULSE_WIDTH - 1);
    end else if (pulse_q) begin
      if (pcnt_q == '0) pulse_d = 1'b0;
      else              pcnt_d  = pcnt_q - PW'(1);
    end
    if (step_evt && bus.dedge) tog_d = ~tog_q;

    if (push) wr_ptr_d = wr_ptr_q + CW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + CW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
      pulse_q  <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
      pulse_q  <= pulse_d;
      pcnt_q   <= pcnt_d;
    end
  end

  // Position, direction, time base and dedge level survive reset (homing).
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.queue_wr_data;
    interval_q <= interval_d;
    count_q    <= count_d;
    add_q      <= add_d;
    nst_q      <= nst_d;
    last_q     <= last_d;
    pos_q      <= pos_d;
    dir_q      <= dir_d;
    tog_q      <= tog_d;
  end

  assign bus.step           = bus.dedge ? tog_q : pulse_q;
  assign bus.dir            = dir_q;
  assign bus.position       = pos_q;
  assign bus.next_step_time = (state_q == S_RUN) ? nst_q : last_q;
  assign bus.missed_clock   = missed_q;
  assign bus.queue_empty    = fifo_empty;
  assign bus.queue_full     = fifo_full;
  assign bus.elemcnt        = cnt_q;
  assign bus.debug          = {state_q == S_RUN, pulse_q, dir_q, missed_q, 8'h00, 4'(cnt_q)};
endmodule

`default_nettype wire

// File: tb/tb_stepdir_channel.sv
// ----------------------------------------------------------------------------
// tb_stepdir_channel: directed and random moves against a queue-based model.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_stepdir_channel;
  localparam int unsigned MOVE_COUNT  = 16;
  localparam int unsigned PULSE_WIDTH = 20;

  typedef struct packed {
    bit        d;
    bit [31:0] ival;
    bit [31:0] cnt;
    bit [31:0] add;
    bit [2:0]  typ;
  } move_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stepdir_channel_if bus ();
  stepdir_channel dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state, in terms of moves and step times.
  move_t       mq[$];
  bit          m_busy = 0, m_dir = 0, m_missed = 0, m_tog = 0;
  bit [31:0]   m_left = 0, m_ival = 0, m_add = 0, m_next = 0, m_last = 0, m_pos = 0;
  int          m_pulse = 0;

  logic [31:0] systime = 0;
  bit          dg_next = 0;
  logic        prev_step = 1'b0;
  logic [31:0] rises[$];
  logic [31:0] edges[$];
  int          hi_cnt = 0;
  move_t       nomv = '0;

  function automatic bit late(input bit [31:0] x);
    return x >= 32'hC000_0000;
  endfunction

  function automatic move_t mk(input bit d, input bit [31:0] ival, input bit [31:0] cnt,
                               input bit [31:0] add, input bit [2:0] typ);
    move_t m;
    m.d = d; m.ival = ival; m.cnt = cnt; m.add = add; m.typ = typ;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_missed = 0; m_pulse = 0;
  endtask

  task automatic model_edge(input bit rst, input bit wr, input move_t mv, input bit drc,
                            input bit [31:0] rc, input bit dg, input bit [31:0] c);
    bit        fired = 0;
    bit        push_ok;
    bit [31:0] nl = m_last;
    move_t     e;
    if (rst) begin
      model_reset();
      if (drc) m_last = rc;
      return;
    end
    push_ok = wr && (mq.size() < MOVE_COUNT - 1);
    if (!m_busy) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.typ == 3'b000 && e.cnt != 0) begin
          m_busy = 1; m_left = e.cnt; m_ival = e.ival; m_add = e.add; m_dir = e.d;
          m_next = m_last + e.ival;
          if (late(m_next - c)) m_missed = 1;
        end
      end
    end else if (m_next == c || late(m_next - c)) begin
      fired  = 1;
      m_pos  = m_dir ? m_pos + 1 : m_pos - 1;
      nl     = m_next;
      m_ival = m_ival + m_add;
      m_next = m_next + m_ival;
      m_left = m_left - 1;
      if (m_left == 0) m_busy = 0;
      else if (late(m_next - c)) m_missed = 1;
    end
    if (push_ok) mq.push_back(mv);
    m_last = drc ? rc : nl;
    if (fired && !dg) m_pulse = PULSE_WIDTH;
    else if (m_pulse > 0) m_pulse--;
    if (fired && dg) m_tog = ~m_tog;
  endtask

  task automatic compare_all();
    logic step_e;
    step_e = bus.dedge ? m_tog : (m_pulse > 0);
    check_val("step", bus.step, step_e);
    check_val("dir", bus.dir, m_dir);
    check_val("position", bus.position, m_pos);
    check_val("elemcnt", bus.elemcnt, mq.size());
    check_val("queue_empty", bus.queue_empty, mq.size() == 0);
    check_val("queue_full", bus.queue_full, mq.size() == MOVE_COUNT - 1);
    check_val("next_step_time", bus.next_step_time, m_busy ? m_next : m_last);
    check_val("missed_clock", bus.missed_clock, m_missed);
    check_val("debug", bus.debug, {m_busy, m_pulse > 0, m_dir, m_missed, 8'h00, 4'(mq.size())});
  endtask

  task automatic cycle(input bit wr, input move_t mv, input bit drc, input logic [31:0] rc);
    compare_all();
    if (bus.step !== prev_step) begin
      edges.push_back(systime + 1);
      if (bus.step) rises.push_back(systime + 1);
    end
    if (bus.step) hi_cnt++;
    prev_step = bus.step;
    systime++;
    bus.clock          = systime;
    bus.dedge          = dg_next;
    bus.queue_wr_en    = wr;
    bus.queue_wr_data  = mv;
    bus.do_reset_clock = drc;
    bus.reset_clock    = rc;
    model_edge(reset, wr, mv, drc, rc, dg_next, systime);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, nomv, 1'b0, 32'd0);
  endtask

  task automatic clear_trace();
    rises.delete();
    edges.delete();
    hi_cnt = 0;
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((m_busy || mq.size() != 0 || m_pulse > 0) && n < max) begin
      idle_cycle();
      n++;
    end
    check_val("idle_timeout", n >= max, 1'b0);
    repeat (3) idle_cycle();
  endtask

  task automatic async_reset(input int hold);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (hold) idle_cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_t[3];
    bus.queue_wr_en = 0; bus.queue_wr_data = '0; bus.dedge = 0;
    bus.do_reset_clock = 0; bus.reset_clock = 0; bus.clock = 0;
    @(negedge clk);
    async_reset(3);
    repeat (2) idle_cycle();

    // Single constant-speed move in pulse mode.
    dg_next = 0; clear_trace();
    cycle(1'b1, mk(1'b1, 100, 3, 0, 3'b000), 1'b1, 32'd999);
    run_until_idle(3000);
    exp_t = '{32'd1100, 32'd1200, 32'd1300};
    check_val("s1_rise_count", rises.size(), 3);
    for (int i = 0; i < 3; i++)
      if (rises.size() > i) check_val("s1_rise_time", rises[i], exp_t[i]);
    check_val("s1_high_clocks", hi_cnt, 3 * PULSE_WIDTH);
    check_val("s1_position", bus.position, 32'd3);
    check_val("s1_empty", bus.queue_empty, 1'b1);

    // Accelerating move, negative direction.
    clear_trace();
    cycle(1'b1, mk(1'b0, 100, 3, 10, 3'b000), 1'b0, 32'd0);
    run_until_idle(3000);
    exp_t = '{32'd1400, 32'd1510, 32'd1630};
    check_val("s2_rise_count", rises.size(), 3);
    for (int i = 0; i < 3; i++)
      if (rises.size() > i) check_val("s2_rise_time", rises[i], exp_t[i]);
    check_val("s2_position", bus.position, 32'd0);

    // Double-edge mode, two back-to-back moves.
    dg_next = 1; clear_trace();
    cycle(1'b1, mk(1'b1, 50, 2, 0, 3'b000), 1'b0, 32'd0);
    cycle(1'b1, mk(1'b1, 30, 1, 0, 3'b000), 1'b0, 32'd0);
    run_until_idle(3000);
    exp_t = '{32'd1680, 32'd1730, 32'd1760};
    check_val("s3_toggle_count", edges.size(), 3);
    for (int i = 0; i < 3; i++)
      if (edges.size() > i) check_val("s3_toggle_time", edges[i], exp_t[i]);
    check_val("s3_position", bus.position, 32'd3);

    // Fill the queue behind a long move, then overflow by one.
    clear_trace();
    cycle(1'b1, mk(1'b0, 1000000, 1, 0, 3'b000), 1'b0, 32'd0);
    for (int i = 0; i < 15; i++) cycle(1'b1, mk(1'b1, 5, 1, 0, 3'b000), 1'b0, 32'd0);
    check_val("s4_full", bus.queue_full, 1'b1);
    check_val("s4_elemcnt", bus.elemcnt, 4'd15);
    cycle(1'b1, mk(1'b1, 5, 1, 0, 3'b000), 1'b0, 32'd0);
    check_val("s4_drop_elemcnt", bus.elemcnt, 4'd15);
    async_reset(2);
    check_val("s4_rst_empty", bus.queue_empty, 1'b1);
    check_val("s4_rst_position", bus.position, 32'd3);

    // Past deadline, then reset in the middle of the resulting pulse.
    dg_next = 0; clear_trace();
    cycle(1'b1, mk(1'b1, 10, 1, 0, 3'b000), 1'b1, systime - 32'd1000);
    repeat (3) idle_cycle();
    check_val("s5_missed", bus.missed_clock, 1'b1);
    check_val("s5_position", bus.position, 32'd4);
    check_val("s5_step_high", bus.step, 1'b1);
    check_val("s5_rise_count", rises.size(), 1);
    reset = 1'b1;
    #1;
    check_val("s6_async_step_low", bus.step, 1'b0);
    check_val("s6_missed_clear", bus.missed_clock, 1'b0);
    check_val("s6_empty", bus.queue_empty, 1'b1);
    check_val("s6_position", bus.position, 32'd4);
    model_reset();
    repeat (2) idle_cycle();
    reset = 1'b0;
    clear_trace();
    repeat (40) idle_cycle();
    check_val("s6_no_steps", rises.size(), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          wr;
      bit          drc;
      move_t       mv;
      logic [31:0] rc;
      wr  = ($urandom % 5) == 0;
      mv  = mk(1'($urandom % 2), 15 + ($urandom % 40), $urandom % 4, ($urandom % 7) - 3,
               (($urandom % 8) == 0) ? 3'(($urandom % 7) + 1) : 3'b000);
      drc = ($urandom % 200) == 0;
      rc  = systime + ($urandom % 30) - 10;
      if (($urandom % 300) == 0) dg_next = ~dg_next;
      if (($urandom % 500) == 0) async_reset(1);
      else cycle(wr, mv, drc, rc);
    end
    run_until_idle(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire
